// File: rtl/cmd_issuer.sv
// Host-side command transmitter: queues 32-bit words and presents each on
// cmd_data with one latch_data pulse shaped for an edge-detecting capture.
module cmd_issuer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   in_cmd,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [31:0]                   cmd_data,
  output logic                          latch_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   issued_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_ZERO   = LW'(0);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ZERO   = PW'(0);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [3:0]    SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0]    HOLD_LAST  = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0]    GAP_LAST   = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [3:0]     cnt_r;
  logic [3:0]     cnt_s;
  logic [31:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [LW-1:0]  level_r;
  logic [LW-1:0]  level_s;
  logic [31:0]    cmd_r;
  logic           latch_r;
  logic           busy_r;
  logic [15:0]    issued_r;
  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;

  assign full_s  = (level_r == FULL_LEVEL);
  assign empty_s = (level_r == LVL_ZERO);
  // flush wins over both sides of the FIFO so a dropped word never reappears
  assign push_s  = in_valid & ~full_s & ~flush;
  assign pop_s   = (state_r == IDLE) & ~empty_s & ~flush;

  assign in_ready     = ~full_s;
  assign fifo_level   = level_r;
  assign cmd_data     = cmd_r;
  assign latch_data   = latch_r;
  assign busy         = busy_r;
  assign issued_count = issued_r;

  // Next FIFO occupancy.
  always_comb begin
    level_s = level_r;
    if (flush) begin
      level_s = LVL_ZERO;
    end else if (push_s && !pop_s) begin
      level_s = level_r + LVL_ONE;
    end else if (!push_s && pop_s) begin
      level_s = level_r - LVL_ONE;
    end else begin
      level_s = level_r;
    end
  end

  // Issue sequencer next state: each phase is timed by the shared counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          state_s = SETUP;
          cnt_s   = 4'd0;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = STROBE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      STROBE: begin
        if (cnt_r == HOLD_LAST) begin
          state_s = GAP;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_cmd;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_s;
    end
  end

  // Sequencer state plus registered strobe, word and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      cmd_r    <= 32'h0000_0000;
      latch_r  <= 1'b0;
      busy_r   <= 1'b0;
      issued_r <= 16'h0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      latch_r <= (state_s == STROBE);
      busy_r  <= (state_s != IDLE) || (level_s != LVL_ZERO);
      if (pop_s) begin
        cmd_r <= mem_r[rd_ptr_r];
      end
      if ((state_r == SETUP) && (state_s == STROBE)) begin
        issued_r <= issued_r + 16'd1;
      end
    end
  end

endmodule
